bayer_to_gray: RTL and testbench
================================

# bayer_to_gray

Converts the raw 12-bit Bayer stream from the camera capture path into the 8-bit grayscale pixel stream that feeds the Sobel edge stage. It consumes a RAW_WIDTH x RAW_HEIGHT Bayer frame. Each 2x2 quad (G1 R / B G2) is collapsed into one gray pixel, so the output is a (RAW_WIDTH/2) x (RAW_HEIGHT/2) stream with gray/valid framing. A single line buffer holds the even raw row until its odd partner row arrives.

## Interface
- RAW_WIDTH, 1280: raw pixels per row. Must be even.
- RAW_HEIGHT, 960: raw rows per frame. Must be even.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- iRaw  input  12  raw Bayer sample.
- iDVAL  input  1  iRaw valid this cycle. Gaps of any length are allowed.
- oGray  output  8  gray pixel. Holds its value between valid pulses.
- oDVAL  output  1  one-cycle pulse per gray pixel.
- oSOF  output  1  asserted together with oDVAL for output pixel (0,0) of each frame only.

## Operation
- Raw position counters col (0..RAW_WIDTH-1) and row (0..RAW_HEIGHT-1) advance only on iDVAL.
  - col wraps to 0 and increments row.
  - row wraps to 0 after RAW_HEIGHT-1.
- Bayer layout:
  - Even row: even col = G1, odd col = R.
  - Odd row: even col = B, odd col = G2.
- Even raw rows: each iDVAL sample is written to line_buf[col], which is RAW_WIDTH x 12. These rows produce no output.
- Odd raw rows:
  - Read line_buf[col] with a registered read, updated only on iDVAL.
  - Even col: capture B, and capture G1 from the buffer.
  - Odd col: capture G2, and capture R from the buffer. This completes a quad.
- Gray arithmetic, default:
  - sum = R + G1 + G2 + B, 14 bits unsigned.
  - oGray = sum[13:6], i.e. the mean, truncated to its top 8 bits.
- Output pixel index = (row>>1, col>>1). Pixels are produced in raster order, (RAW_WIDTH/2)*(RAW_HEIGHT/2) per frame.
- oSOF marks the quad completed at raw row 1, col 1.
- Line buffer contents are never cleared. Stale data is harmless because every odd row is preceded by a fresh even row.

## Timing
- Reset values: oGray = 0, oDVAL = 0, oSOF = 0. col, row and all pipeline valids = 0.
- Latency: oDVAL/oGray/oSOF register 2 clocks after the iDVAL cycle carrying G2. This is independent of iDVAL gaps; a gap inside a quad only delays completion.
- Throughput: at most one output per 2 accepted input samples, and none during even rows. A continuous iDVAL gives back-to-back output pulses spaced 2 clocks apart.
- A pipeline stage holds its value when iDVAL is low, except the final 2-stage output pipe, which always advances.
- Reset mid-frame:
  - oDVAL/oSOF are 0 in the cycle after rst, with no pending outputs emitted.
  - The next iDVAL sample is treated as raw (0,0).
- rst and iDVAL asserted together: the sample is dropped and counters stay at 0.
- Frame wrap: after raw (RAW_HEIGHT-1, RAW_WIDTH-1), the next sample is (0,0). The next frame's first output asserts oSOF again.

## Configuration
- WEIGHTED_LUMA_EN defined:
  - y = 77*R + 75*(G1+G2) + 29*B, 20 bits unsigned, max 1048320.
  - oGray = y[19:12].
  - Latency and framing are identical to the default.
- WEIGHTED_LUMA_EN undefined: plain 4-sample mean as above. No multipliers are inferred.

## Test plan
- Uniform frame, RAW_WIDTH=8, RAW_HEIGHT=4, all iRaw=4095, continuous iDVAL:
  - exactly 8 oDVAL pulses, all oGray=255;
  - oSOF only on the first pulse;
  - each pulse 2 clocks after its G2 sample.
- Single quad G1=0, R=4000, B=0, G2=0 -> oGray=62 by default; oGray=75 with WEIGHTED_LUMA_EN.
- Quad G1=100, R=200, B=300, G2=400 -> oGray=15 in both builds. Even rows show oDVAL=0 throughout.
- Random iDVAL gaps of 0-5 cycles over 2 frames of random data -> output sequence matches the golden model bit-exactly, with 8 pixels per frame and oSOF on pixels 0 and 8.
- rst pulsed mid-row 1 at raw col 5:
  - oDVAL=0 from the next cycle;
  - no output from the interrupted quad;
  - the following frame starts at (0,0) with oSOF and correct values.
- Frame wrap with no idle between frames -> no extra or missing pulses at the boundary, and oGray holds its last value while oDVAL=0.

Source files
------------

// File: rtl/bayer_to_gray.sv
// bayer_to_gray: collapses each 2x2 Bayer quad (G1 R / B G2) of a 12-bit raw
// frame into one 8-bit gray pixel. The even raw row is parked in a single line
// buffer until its odd partner row streams in.
//
// Build option: define WEIGHTED_LUMA_EN to use the weighted luma
// y = 77*R + 75*(G1+G2) + 29*B instead of the plain 4-sample mean.
// Latency and framing are the same in both builds.
module bayer_to_gray #(
    parameter int unsigned RAW_WIDTH  = 1280,
    parameter int unsigned RAW_HEIGHT = 960
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] iRaw,
    input  logic        iDVAL,
    output logic [7:0]  oGray,
    output logic        oDVAL,
    output logic        oSOF
);

    localparam int unsigned ColW = (RAW_WIDTH > 1) ? $clog2(RAW_WIDTH) : 1;
    localparam int unsigned RowW = (RAW_HEIGHT > 1) ? $clog2(RAW_HEIGHT) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(RAW_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(RAW_HEIGHT - 1);

`ifdef WEIGHTED_LUMA_EN
    localparam int unsigned AccW = 20;
`else
    localparam int unsigned AccW = 14;
`endif

    // Raw position counters
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            row_odd;
    logic            col_odd;

    // Line buffer and its registered read port
    logic [11:0] line_buf [RAW_WIDTH];
    logic [11:0] rd_q;

    // Quad capture stage
    logic [11:0] b_q;
    logic [11:0] g1_q;
    logic [11:0] g2_q;
    logic        quad_vld_q;
    logic        quad_sof_q;

    // Output pipe: accumulate stage, then output registers
    logic [AccW-1:0] acc_d, acc_q;
    logic            vld_a_q;
    logic            sof_a_q;
    logic [7:0]      gray_a;

    assign row_odd = row_q[0];
    assign col_odd = col_q[0];

    // Next raw position: advance on each accepted sample, wrap at row/frame end
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (iDVAL) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    // Line buffer: write during even rows, registered read during odd rows.
    // No reset: stale contents are always overwritten by the next even row.
    always_ff @(posedge clk) begin
        if (iDVAL) begin
            if (!row_odd) begin
                line_buf[col_q] <= iRaw;
            end else begin
                rd_q <= line_buf[col_q];
            end
        end
    end

    // Position counters and quad capture; a sample arriving with rst is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            b_q        <= '0;
            g1_q       <= '0;
            g2_q       <= '0;
            quad_vld_q <= 1'b0;
            quad_sof_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            quad_vld_q <= 1'b0;
            quad_sof_q <= 1'b0;
            if (iDVAL && row_odd) begin
                if (!col_odd) begin
                    // rd_q picks up G1 on this same edge
                    b_q <= iRaw;
                end else begin
                    // rd_q still holds G1 here; it picks up R on this edge
                    g1_q       <= rd_q;
                    g2_q       <= iRaw;
                    quad_vld_q <= 1'b1;
                    quad_sof_q <= (row_q == RowW'(1)) && (col_q == ColW'(1));
                end
            end
        end
    end

`ifdef WEIGHTED_LUMA_EN
    // Weighted luma; coefficients sum to 256 so a full-scale quad maps to 255
    always_comb begin
        acc_d = 20'd77 * {8'd0, rd_q}
              + 20'd75 * ({8'd0, g1_q} + {8'd0, g2_q})
              + 20'd29 * {8'd0, b_q};
        gray_a = acc_q[19:12];
    end
`else
    // Plain mean: 4-sample sum, top 8 bits
    always_comb begin
        acc_d  = {2'b00, rd_q} + {2'b00, g1_q} + {2'b00, g2_q} + {2'b00, b_q};
        gray_a = acc_q[13:6];
    end
`endif

    // Accumulate stage: valids always advance, data loads only on a new quad
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            vld_a_q <= 1'b0;
            sof_a_q <= 1'b0;
        end else begin
            vld_a_q <= quad_vld_q;
            sof_a_q <= quad_sof_q;
            if (quad_vld_q) begin
                acc_q <= acc_d;
            end
        end
    end

    // Output registers: oGray holds between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            oGray <= '0;
            oDVAL <= 1'b0;
            oSOF  <= 1'b0;
        end else begin
            oDVAL <= vld_a_q;
            oSOF  <= vld_a_q & sof_a_q;
            if (vld_a_q) begin
                oGray <= gray_a;
            end
        end
    end

endmodule

// File: tb/tb_bayer_to_gray.sv
// Self-checking bench for bayer_to_gray on a small 8x4 raw frame.
// The model rebuilds the raw frame from the driven samples, forms each quad
// from frame coordinates and schedules its gray pixel 2 clocks after the G2
// sample; outputs are compared against that schedule on every cycle.
module tb_bayer_to_gray;

    localparam int W = 8;
    localparam int H = 4;
`ifdef WEIGHTED_LUMA_EN
    localparam int Exp4000 = 75;
`else
    localparam int Exp4000 = 62;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] iRaw;
    logic        iDVAL;
    logic [7:0]  oGray;
    logic        oDVAL;
    logic        oSOF;

    always #5 clk = ~clk;

    bayer_to_gray #(
        .RAW_WIDTH (W),
        .RAW_HEIGHT(H)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .iRaw (iRaw),
        .iDVAL(iDVAL),
        .oGray(oGray),
        .oDVAL(oDVAL),
        .oSOF (oSOF)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] g;
        logic       sof;
        longint     due;
    } exp_t;

    longint     cyc = 0;
    int         fr [H][W];
    int         pos = 0;
    exp_t       q[$];
    logic       exp_dval = 1'b0;
    logic       exp_sof  = 1'b0;
    logic [7:0] exp_gray = 8'd0;

    function automatic logic [7:0] model_gray(int g1, int r, int b, int g2);
`ifdef WEIGHTED_LUMA_EN
        return 8'((77 * r + 75 * (g1 + g2) + 29 * b) / 4096);
`else
        return 8'((r + g1 + g2 + b) / 64);
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model: edge number e = cyc + 1 (cyc still holds the previous count)
    always @(posedge clk) begin
        longint e;
        int     r;
        int     c;
        exp_t   x;
        e = cyc + 1;
        if (rst) begin
            pos = 0;
            q.delete();
            exp_dval = 1'b0;
            exp_sof  = 1'b0;
            exp_gray = 8'd0;
        end else begin
            exp_dval = 1'b0;
            exp_sof  = 1'b0;
            if (q.size() > 0 && q[0].due == e) begin
                exp_dval = 1'b1;
                exp_gray = q[0].g;
                exp_sof  = q[0].sof;
                void'(q.pop_front());
            end
            if (iDVAL) begin
                r = pos / W;
                c = pos % W;
                fr[r][c] = int'(iRaw);
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    x.g   = model_gray(fr[r-1][c-1], fr[r-1][c], fr[r][c-1], fr[r][c]);
                    x.sof = (r == 1) && (c == 1);
                    x.due = e + 2;
                    q.push_back(x);
                end
                pos = (pos + 1) % (W * H);
            end
        end
    end

    // ---------------- checking ----------------
    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    int         sofs   = 0;
    logic [7:0] dut_g[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare the state left by the most recent edge, then advance one cycle
    task automatic tick();
        @(negedge clk);
        chk("oDVAL", 32'(oDVAL), 32'(exp_dval));
        chk("oSOF", 32'(oSOF), 32'(exp_sof));
        chk("oGray", 32'(oGray), 32'(exp_gray));
        if (oDVAL === 1'b1) begin
            pulses++;
            dut_g.push_back(oGray);
        end
        if (oSOF === 1'b1) sofs++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] d, input int gap);
        repeat (gap) begin
            iDVAL = 1'b0;
            iRaw  = 12'($urandom);
            tick();
        end
        iDVAL = 1'b1;
        iRaw  = d;
        tick();
        iDVAL = 1'b0;
    endtask

    function automatic logic [11:0] gen(int mode, int r, int c);
        case (mode)
            0: return 12'd4095;
            1: return (r == 0 && c == 1) ? 12'd4000 : 12'd0;
            2: return (r % 2 == 0) ? ((c % 2 == 0) ? 12'd100 : 12'd200)
                                   : ((c % 2 == 0) ? 12'd300 : 12'd400);
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic send_frame(input int mode, input int gapmax);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(gen(mode, r, c), (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
            end
        end
    endtask

    task automatic drain();
        repeat (6) tick();
    endtask

    int pb;
    int sb;

    initial begin
        rst   = 1'b1;
        iDVAL = 1'b0;
        iRaw  = 12'd0;
        @(posedge clk);
        #1;
        tick();
        chk("reset_oGray", 32'(oGray), 32'd0);
        chk("reset_oDVAL", 32'(oDVAL), 32'd0);
        chk("reset_oSOF", 32'(oSOF), 32'd0);
        rst = 1'b0;

        // Uniform full-scale, two frames back to back (frame wrap)
        pb = pulses; sb = sofs;
        repeat (2) send_frame(0, 0);
        drain();
        chk("uniform_pulses", 32'(pulses - pb), 32'd16);
        chk("uniform_sofs", 32'(sofs - sb), 32'd2);
        chk("uniform_gray", 32'(dut_g[dut_g.size()-1]), 32'd255);

        // Single bright R in quad (0,0)
        pb = pulses; sb = sofs;
        send_frame(1, 0);
        drain();
        chk("r4000_pulses", 32'(pulses - pb), 32'd8);
        chk("r4000_gray", 32'(dut_g[pb]), 32'(Exp4000));
        chk("r4000_next_gray", 32'(dut_g[pb+1]), 32'd0);

        // Quad 100/200/300/400 everywhere, with gaps
        pb = pulses;
        send_frame(2, 3);
        drain();
        chk("q1234_pulses", 32'(pulses - pb), 32'd8);
        chk("q1234_first", 32'(dut_g[pb]), 32'd15);
        chk("q1234_last", 32'(dut_g[pb+7]), 32'd15);

        // Two random frames with random gaps of 0-5 cycles
        pb = pulses; sb = sofs;
        repeat (2) send_frame(3, 5);
        drain();
        chk("rand_pulses", 32'(pulses - pb), 32'd16);
        chk("rand_sofs", 32'(sofs - sb), 32'd2);

        // Reset in mid raw row 1 at col 5, asserted together with a sample
        for (int i = 0; i < W + 6; i++) send(12'($urandom), int'($urandom_range(2, 0)));
        rst   = 1'b1;
        iDVAL = 1'b1;
        iRaw  = 12'($urandom);
        tick();
        rst   = 1'b0;
        iDVAL = 1'b0;
        chk("rst_next_oDVAL", 32'(oDVAL), 32'd0);
        pb = pulses;
        drain();
        chk("rst_no_pulse", 32'(pulses - pb), 32'd0);
        pb = pulses; sb = sofs;
        send_frame(3, 2);
        drain();
        chk("after_rst_pulses", 32'(pulses - pb), 32'd8);
        chk("after_rst_sofs", 32'(sofs - sb), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
